// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier; division is unchanged.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [2:0]  op;
  logic [63:0] acc;
  logic [31:0] mcand;
  logic        neg;
  logic        neg_r;

  logic        a_signed, b_signed, a_neg, b_neg, is_div, b_zero, ovf;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    is_div   = funct3[2];
    a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b110);
    b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
    a_neg    = a_signed & op_a[31];
    b_neg    = b_signed & op_b[31];
    a_mag    = a_neg ? (~op_a + 32'd1) : op_a;
    b_mag    = b_neg ? (~op_b + 32'd1) : op_b;
    b_zero   = (op_b == 32'd0);
    ovf      = a_signed && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fa, fb, fprod;
  always_comb begin
    fa    = {{32{a_signed & op_a[31]}}, op_a};
    fb    = {{32{b_signed & op_b[31]}}, op_b};
    fprod = fa * fb;
  end
`endif

  // Multiply: acc = {partial high, multiplier}; shifts right with the adder carry.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  // Divide: acc = {remainder, quotient}; quotient bits enter from the right.
  logic [32:0] div_sh;
  logic        div_ge;
  logic [31:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? mcand : 32'd0)};
    mul_next = {mul_sum, acc[31:1]};
    div_sh   = {acc[63:32], acc[31]};
    div_ge   = (div_sh >= {1'b0, mcand});
    div_diff = div_sh[31:0] - mcand;
    div_next = {(div_ge ? div_diff : div_sh[31:0]), acc[30:0], div_ge};
  end

  logic [63:0] prod;
  logic [31:0] quo_fix, rem_fix, fix_res;

  always_comb begin
    prod    = neg ? (~acc + 64'd1) : acc;
    quo_fix = neg ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix = neg_r ? (~acc[63:32] + 32'd1) : acc[63:32];
    if (op[2])
      fix_res = op[1] ? rem_fix : quo_fix;
    else
      fix_res = (op[1:0] == 2'b00) ? prod[31:0] : prod[63:32];
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      op     <= 3'd0;
      acc    <= 64'd0;
      mcand  <= 32'd0;
      neg    <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op  <= funct3;
            cnt <= 5'd0;
            if (!is_div) begin
              mcand <= a_mag;
              neg_r <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              acc   <= fprod;
              neg   <= 1'b0;
              state <= S_FIX;
`else
              acc   <= {32'd0, b_mag};
              neg   <= a_neg ^ b_neg;
              state <= S_CALC;
`endif
            end else if (b_zero) begin
              // Preload so that FIX yields all-ones quotient and op_a remainder.
              acc   <= {op_a, 32'hFFFF_FFFF};
              mcand <= 32'd0;
              neg   <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end else if (ovf) begin
              acc   <= {32'd0, 32'h8000_0000};
              mcand <= 32'd0;
              neg   <= 1'b0;
              neg_r <= 1'b0;
              state <= S_FIX;
            end else begin
              acc   <= {32'd0, a_mag};
              mcand <= b_mag;
              neg   <= a_neg ^ b_neg;
              neg_r <= a_neg;
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          cnt <= cnt + 5'd1;
          acc <= op[2] ? div_next : mul_next;
          if (cnt == 5'd31)
            state <= S_FIX;
        end
        S_FIX: begin
          result <= fix_res;
          done   <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
